// File: rtl/data_mem_responder.sv
// Data-memory responder: serves single-word read/write requests after a fixed
// number of wait states, and zeroes the whole RAM as a one-word-per-cycle sweep.
module data_mem_responder #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memReq,
    input  logic              memWe,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] writeData,
    input  logic              memClr,
    output logic              dataReady,
    output logic [DATA_W-1:0] readData,
    output logic              busy
);

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [3:0]        WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [3:0]        cnt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] req_addr;
    logic              req_we;
    logic [DATA_W-1:0] req_data;

    logic              access_done;
    logic              clear_last;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;

    // RAM is deliberately not reset; a write is only enabled from BUSY/CLEAR,
    // so an asynchronous reset (which forces IDLE) also cancels any pending write.
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (memClr) begin
                    state_next = ST_CLEAR;
                end else if (memReq) begin
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (memClr) begin
                    state_next = ST_CLEAR;
                end else if (cnt == 4'd0) begin
                    state_next = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (ptr == LAST_ADDR) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != ST_IDLE);
        access_done = (state == ST_BUSY) && !memClr && (cnt == 4'd0);
        clear_last  = (state == ST_CLEAR) && (ptr == LAST_ADDR);
        ram_we      = (access_done && req_we) || (state == ST_CLEAR);
        ram_waddr   = (state == ST_CLEAR) ? ptr : req_addr;
        ram_wdata   = (state == ST_CLEAR) ? '0 : req_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= 4'd0;
            ptr       <= '0;
            req_addr  <= '0;
            req_we    <= 1'b0;
            req_data  <= '0;
            dataReady <= 1'b0;
            readData  <= '0;
        end else begin
            dataReady <= access_done || clear_last;
            if (access_done && !req_we) begin
                readData <= mem[req_addr];
            end
            case (state)
                ST_IDLE: begin
                    if (memClr) begin
                        ptr <= '0;
                    end else if (memReq) begin
                        req_addr <= addr;
                        req_we   <= memWe;
                        req_data <= writeData;
                        cnt      <= WAIT_INIT;
                    end
                end
                ST_BUSY: begin
                    if (memClr) begin
                        ptr <= '0;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_CLEAR: ptr <= ptr + 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: instance 0 has WAIT_STATES=2/ADDR_W=8, instance 1 has
// WAIT_STATES=0/ADDR_W=4 for back-to-back traffic and a short full clear.
module tb_data_mem_responder;

    logic        clk;
    logic        reset;
    logic        mem_req  [2];
    logic        mem_we   [2];
    logic        mem_clr  [2];
    logic [7:0]  addr_s   [2];
    logic [15:0] wdata    [2];
    logic        data_rdy [2];
    logic        busy_s   [2];
    logic [15:0] rdata    [2];

    int n_cmp;
    int n_err;

    data_mem_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_STATES(2)) u_ws2 (
        .clk       (clk),
        .reset     (reset),
        .memReq    (mem_req[0]),
        .memWe     (mem_we[0]),
        .addr      (addr_s[0]),
        .writeData (wdata[0]),
        .memClr    (mem_clr[0]),
        .dataReady (data_rdy[0]),
        .readData  (rdata[0]),
        .busy      (busy_s[0])
    );

    data_mem_responder #(.DATA_W(16), .ADDR_W(4), .WAIT_STATES(0)) u_ws0 (
        .clk       (clk),
        .reset     (reset),
        .memReq    (mem_req[1]),
        .memWe     (mem_we[1]),
        .addr      (addr_s[1][3:0]),
        .writeData (wdata[1]),
        .memClr    (mem_clr[1]),
        .dataReady (data_rdy[1]),
        .readData  (rdata[1]),
        .busy      (busy_s[1])
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Starts and ends at a negedge. lat = k where dataReady is seen in the
    // cycle after edge E+k (E = sampling edge); -1 on timeout.
    task automatic access(input int d, input logic we, input logic [7:0] a,
                          input logic [15:0] wd, output int lat, output int bcnt);
        mem_req[d] = 1'b1;
        mem_we[d]  = we;
        addr_s[d]  = a;
        wdata[d]   = wd;
        @(posedge clk);
        @(negedge clk);
        mem_req[d] = 1'b0;
        lat  = -1;
        bcnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (data_rdy[d]) begin
                lat = k;
                break;
            end
            bcnt += int'(busy_s[d]);
            @(negedge clk);
        end
    endtask

    task automatic do_clear(input int d, output int lat);
        mem_clr[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_clr[d] = 1'b0;
        lat = -1;
        for (int k = 0; k < 400; k++) begin
            if (data_rdy[d]) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int lat;
        int bcnt;
        int pulses;
        n_cmp = 0;
        n_err = 0;
        for (int d = 0; d < 2; d++) begin
            mem_req[d] = 1'b0;
            mem_we[d]  = 1'b0;
            mem_clr[d] = 1'b0;
            addr_s[d]  = '0;
            wdata[d]   = '0;
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_busy", 32'(busy_s[d]), 32'd0);
            check("rst_ready", 32'(data_rdy[d]), 32'd0);
            check("rst_rdata", 32'(rdata[d]), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        // write then read, WAIT_STATES=2
        access(0, 1'b1, 8'h10, 16'hBEEF, lat, bcnt);
        check("wr_latency", 32'(lat), 32'd3);
        check("wr_busy_cycles", 32'(bcnt), 32'd3);
        @(negedge clk);
        check("wr_pulse_width", 32'(data_rdy[0]), 32'd0);
        access(0, 1'b0, 8'h10, 16'h0000, lat, bcnt);
        check("rd_latency", 32'(lat), 32'd3);
        check("rd_busy_cycles", 32'(bcnt), 32'd3);
        check("rd_beef", 32'(rdata[0]), 32'hBEEF);
        @(negedge clk);

        // request during BUSY is ignored
        access(0, 1'b1, 8'h20, 16'h0F0F, lat, bcnt);
        @(negedge clk);
        mem_req[0] = 1'b1;
        mem_we[0]  = 1'b0;
        addr_s[0]  = 8'h10;
        @(posedge clk);
        @(negedge clk);
        mem_we[0]  = 1'b1;
        addr_s[0]  = 8'h20;
        wdata[0]   = 16'h5555;
        pulses = 0;
        lat = -1;
        for (int k = 0; k < 12; k++) begin
            if (data_rdy[0]) begin
                pulses++;
                if (lat < 0) lat = k;
                mem_req[0] = 1'b0;
            end
            @(negedge clk);
        end
        mem_req[0] = 1'b0;
        check("ign_latency", 32'(lat), 32'd3);
        check("ign_pulses", 32'(pulses), 32'd1);
        check("ign_rd10", 32'(rdata[0]), 32'hBEEF);
        access(0, 1'b0, 8'h20, 16'h0000, lat, bcnt);
        check("ign_rd20", 32'(rdata[0]), 32'h0F0F);
        @(negedge clk);

        // back-to-back, WAIT_STATES=0
        for (int i = 0; i < 4; i++) begin
            access(1, 1'b1, 8'(i), 16'(16'h1111 * (i + 1)), lat, bcnt);
            check("b2b_wr_latency", 32'(lat), 32'd1);
            access(1, 1'b0, 8'(i), 16'h0000, lat, bcnt);
            check("b2b_rd_latency", 32'(lat), 32'd1);
            check("b2b_rd_data", 32'(rdata[1]), 32'(16'h1111 * (i + 1)));
        end
        @(negedge clk);
        check("b2b_pulse_width", 32'(data_rdy[1]), 32'd0);

        // fill with A5A5 then clear, ADDR_W=4
        for (int i = 0; i < 16; i++) begin
            access(1, 1'b1, 8'(i), 16'hA5A5, lat, bcnt);
        end
        @(negedge clk);
        access(1, 1'b0, 8'h07, 16'h0000, lat, bcnt);
        check("fill_rd7", 32'(rdata[1]), 32'hA5A5);
        @(negedge clk);
        do_clear(1, lat);
        check("clr_latency", 32'(lat), 32'd16);
        check("clr_rdata_hold", 32'(rdata[1]), 32'hA5A5);
        @(negedge clk);
        check("clr_pulse_width", 32'(data_rdy[1]), 32'd0);
        for (int i = 0; i < 16; i++) begin
            access(1, 1'b0, 8'(i), 16'h0000, lat, bcnt);
            check("clr_rd_zero", 32'(rdata[1]), 32'd0);
        end
        @(negedge clk);

        // memClr aborts a pending write
        mem_req[0] = 1'b1;
        mem_we[0]  = 1'b1;
        addr_s[0]  = 8'h05;
        wdata[0]   = 16'h1234;
        @(posedge clk);
        @(negedge clk);
        mem_req[0] = 1'b0;
        mem_clr[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_clr[0] = 1'b0;
        pulses = 0;
        lat = -1;
        for (int k = 0; k < 300; k++) begin
            if (data_rdy[0]) begin
                pulses++;
                if (lat < 0) lat = k;
            end
            @(negedge clk);
        end
        check("abort_pulses", 32'(pulses), 32'd1);
        check("abort_clr_latency", 32'(lat), 32'd256);
        access(0, 1'b0, 8'h05, 16'h0000, lat, bcnt);
        check("abort_rd05", 32'(rdata[0]), 32'd0);
        @(negedge clk);

        // async reset during BUSY cancels the write
        access(0, 1'b1, 8'h30, 16'h0077, lat, bcnt);
        @(negedge clk);
        access(0, 1'b0, 8'h30, 16'h0000, lat, bcnt);
        check("pre_rst_rd30", 32'(rdata[0]), 32'h0077);
        @(negedge clk);
        mem_req[0] = 1'b1;
        mem_we[0]  = 1'b1;
        addr_s[0]  = 8'h30;
        wdata[0]   = 16'h9999;
        @(posedge clk);
        @(negedge clk);
        mem_req[0] = 1'b0;
        check("pre_rst_busy", 32'(busy_s[0]), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_busy", 32'(busy_s[0]), 32'd0);
        check("async_rst_ready", 32'(data_rdy[0]), 32'd0);
        check("async_rst_rdata", 32'(rdata[0]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        access(0, 1'b0, 8'h30, 16'h0000, lat, bcnt);
        check("post_rst_rd30", 32'(rdata[0]), 32'h0077);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the processor's data-memory handshake. It accepts single-word read/write requests from the sequencing controller, holds them for a configurable number of wait states, performs the access on an internal word-addressed RAM, and pulses `dataReady`, the signal the controller's wait states poll. It also implements the controller's data-memory clear as a multi-cycle sweep.

## Interface
- `DATA_W`, default 16: word width.
- `ADDR_W`, default 8: address width; depth = 2^ADDR_W words.
- `WAIT_STATES`, default 2: extra cycles inserted before each access completes; legal range 0..15.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `memReq`  in  1  request strobe; sampled only in IDLE.
- `memWe`  in  1  1 = write, 0 = read; sampled with `memReq`.
- `addr`  in  ADDR_W  word address; sampled with `memReq`.
- `writeData`  in  DATA_W  store data; sampled with `memReq`.
- `memClr`  in  1  request to zero the entire RAM.
- `dataReady`  out  1  one-cycle completion pulse.
- `readData`  out  DATA_W  last read result.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- States are IDLE, BUSY and CLEAR.
- **Reset (async):**
  - state goes to IDLE.
  - `dataReady` = 0, `readData` = 0, `busy` = 0.
  - internal wait counter and clear pointer = 0.
  - RAM contents are not reset and are undefined until written or cleared.
- **IDLE:**
  - If `memClr` = 1, go to CLEAR with pointer = 0. `memClr` has priority over `memReq`.
  - Else if `memReq` = 1, latch `addr`, `memWe` and `writeData`, load counter = WAIT_STATES, and go to BUSY.
- **BUSY:**
  - While counter ≠ 0, decrement the counter.
  - When counter = 0 at an edge, perform the access:
    - write: RAM[addr] <= data.
    - read: `readData` <= RAM[addr].
  - On that same edge, set `dataReady` <= 1 and return to IDLE.
  - `memReq` is ignored while in BUSY; there is no queue.
  - `memClr` = 1 in BUSY aborts the pending access: the access is not performed, no `dataReady` is issued for it, and the state goes to CLEAR with pointer = 0.
- **CLEAR:**
  - Each edge writes RAM[pointer] <= 0 and increments the pointer.
  - On the edge that writes address 2^ADDR_W−1, set `dataReady` <= 1 and return to IDLE. The pointer wraps to 0.
  - `memReq` and `memClr` are ignored during CLEAR.
- **Outputs:**
  - `dataReady` is registered and is high for exactly one cycle per completed access or clear. It is otherwise 0.
  - `readData` is updated only by a completed read. It holds its value across writes, clears and idle cycles.
- **Requests:** A request held high across the IDLE return is sampled again as a new request. The controller must drop `memReq` once it sees `dataReady`.

## Timing
- Latency: with `memReq` sampled at edge E, `dataReady` is high in the cycle following edge E+WAIT_STATES+1.
  - WAIT_STATES = 0: `dataReady` is high in the cycle after edge E+1.
  - WAIT_STATES = 2: `dataReady` is high in the cycle after edge E+3.
- `readData` becomes valid in the same cycle that `dataReady` rises.
- `busy` rises in the cycle after edge E and falls in the same cycle that `dataReady` rises.
- Earliest back-to-back: a new `memReq` can be sampled at the edge that ends the `dataReady` cycle.
- Clear duration: `memClr` sampled at edge C gives `dataReady` high in the cycle after edge C+2^ADDR_W.
- Read-after-write to the same address always returns the new data, because the accesses are serialized.
- Reset asserted mid-BUSY or mid-CLEAR: the state immediately goes to IDLE and `dataReady` drops.
  - A write whose completion edge has not yet occurred is not performed.
  - A partial clear leaves the remaining words unchanged.

## Test plan
- Write then read, WAIT_STATES = 2:
  - Write 0xBEEF to addr 0x10: `dataReady` pulses 3 edges after the sampling edge.
  - Then read addr 0x10: `readData` = 0xBEEF when `dataReady` pulses; `busy` is high for exactly 3 cycles per access.
- WAIT_STATES = 0 back-to-back traffic:
  - 4 alternating writes/reads on addresses 0x00–0x03 with data 0x1111·(i+1).
  - Each `dataReady` is 1 cycle wide and all reads match.
- Ignored request while BUSY:
  - A second `memReq` (write 0x5555 to 0x20) asserted during BUSY has no effect.
  - A subsequent read of 0x20 returns its prior value; exactly one `dataReady` is produced.
- Clear:
  - Fill all addresses with 0xA5A5 (ADDR_W = 4), then pulse `memClr`.
  - `dataReady` is high 16 edges later; all 16 reads return 0; `readData` is unchanged until the first read.
- `memClr` during BUSY:
  - Issue a write 0x1234 to 0x05, then assert `memClr` before completion.
  - No write `dataReady` is produced; after the clear, addr 0x05 reads 0.
- Async reset mid-access:
  - Assert `reset` between clock edges during BUSY: `busy` and `dataReady` drop immediately and `readData` = 0.
  - After release, a read of the targeted address shows the write was not performed.
